des_ip_loader: RTL

Input-side front end of the DES datapath, the counterpart of the final-permutation stage at the output end. It assembles 64-bit blocks from a byte-serial input stream and applies the DES initial permutation (IP), the exact inverse of the final permutation. It splits each permuted block into L0/R0 halves and queues up to two blocks for the round engine behind a valid/ready handshake. It sits between the host byte interface and the round engine.

---
 rtl/des_pkg.sv | 38 +++
 rtl/des_initial_permutation.sv | 13 +
 rtl/des_ip_loader.sv | 102 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, widths and the
// loader queue entry type.
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int HALF_W  = 32;

    // Indexed by output bit: out[k] = in[IP_TBL[k]] (bit 63 is DES bit 1)
    localparam logic [5:0] IP_TBL [BLOCK_W] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6
    };

    // Inverse of IP_TBL: out[k] = in[FP_TBL[k]]
    localparam logic [5:0] FP_TBL [BLOCK_W] = '{
        6'd39, 6'd7,  6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
        6'd38, 6'd6,  6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
        6'd37, 6'd5,  6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
        6'd36, 6'd4,  6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
        6'd35, 6'd3,  6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
        6'd34, 6'd2,  6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
        6'd33, 6'd1,  6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
        6'd32, 6'd0,  6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
    };

    typedef struct packed {
        logic              tag;
        logic [HALF_W-1:0] l;
        logic [HALF_W-1:0] r;
    } entry_t;

endpackage

// File: rtl/des_initial_permutation.sv
// DES initial permutation: pure 64-bit rewiring from the package table.
module des_initial_permutation
    import des_pkg::*;
(
    input  logic [BLOCK_W-1:0] BlockIn,
    output logic [BLOCK_W-1:0] BlockOut
);

    for (genvar k = 0; k < BLOCK_W; k++) begin : g_bit
        assign BlockOut[k] = BlockIn[IP_TBL[k]];
    end

endmodule

// File: rtl/des_ip_loader.sv
// Byte-serial block assembler feeding IP-permuted L0/R0 halves
// into a small queue for the DES round engine.
module des_ip_loader
    import des_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    input  logic              DecryptIn,
    input  logic              Flush,
    output logic [HALF_W-1:0] LeftOut,
    output logic [HALF_W-1:0] RightOut,
    output logic              DecryptOut,
    output logic              OutValid,
    input  logic              OutReady
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [55:0]        Asm_q;
    logic [2:0]         ByteCnt_q;
    logic               Tag_q;
    entry_t             Ent_q [FIFO_DEPTH];
    logic [PW-1:0]      Wp_q;
    logic [PW-1:0]      Rp_q;
    logic [CW-1:0]      Cnt_q;
    logic [CW-1:0]      Cnt_d;

    logic               byte_xfer;
    logic               push;
    logic               pop;
    logic [BLOCK_W-1:0] ip_blk;
    entry_t             head;

    des_initial_permutation u_ip (
        .BlockIn  ({Asm_q, ByteIn}),
        .BlockOut (ip_blk)
    );

    // Ready looks only at state and Flush so the host never waits on OutReady
    assign ByteReady = !Flush && !(ByteCnt_q == 3'd7 && Cnt_q == FULL);
    assign byte_xfer = ByteValid && ByteReady;
    assign push      = byte_xfer && (ByteCnt_q == 3'd7);
    assign OutValid  = (Cnt_q != '0);
    assign pop       = OutValid && OutReady;

    assign head       = Ent_q[Rp_q];
    assign LeftOut    = head.l;
    assign RightOut   = head.r;
    assign DecryptOut = head.tag;

    always_comb begin
        Cnt_d = Cnt_q;
        if (push && !pop) begin
            Cnt_d = Cnt_q + CW'(1);
        end else if (pop && !push) begin
            Cnt_d = Cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Asm_q     <= '0;
            ByteCnt_q <= '0;
            Tag_q     <= 1'b0;
            Wp_q      <= '0;
            Rp_q      <= '0;
            Cnt_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                Ent_q[i] <= '0;
            end
        end else begin
            if (Flush) begin
                Asm_q     <= '0;
                ByteCnt_q <= '0;
            end else if (byte_xfer) begin
                Asm_q     <= {Asm_q[47:0], ByteIn};
                ByteCnt_q <= ByteCnt_q + 3'd1;
                if (ByteCnt_q == 3'd0) begin
                    Tag_q <= DecryptIn;
                end
            end
            if (push) begin
                Ent_q[Wp_q] <= '{tag: Tag_q,
                                 l:   ip_blk[63:32],
                                 r:   ip_blk[31:0]};
                Wp_q        <= Wp_q + PW'(1);
            end
            if (pop) begin
                Rp_q <= Rp_q + PW'(1);
            end
            Cnt_q <= Cnt_d;
        end
    end

endmodule
